// File: rtl/mem_bus_responder_if.sv
// CPU-side bus of the memory responder: instruction port B, data port A,
// the CPU clock-enable and the hardware-interrupt request.
interface mem_bus_responder_if;
  logic        cpu_ce;
  logic [15:0] b_addr;
  logic [15:0] b_rdata;
  logic [15:0] a_addr;
  logic [1:0]  a_ctrl;
  logic [15:0] a_wdata;
  logic [15:0] a_rdata;
  logic        hw_int_signal;
  logic [3:0]  hw_int_index;

  modport master (
    output b_addr, a_addr, a_ctrl, a_wdata,
    input  cpu_ce, b_rdata, a_rdata, hw_int_signal, hw_int_index
  );

  modport slave (
    input  b_addr, a_addr, a_ctrl, a_wdata,
    output cpu_ce, b_rdata, a_rdata, hw_int_signal, hw_int_index
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Serves CPU instruction and data ports from one async SRAM on a fixed
// fetch/data two-phase schedule, with a UART byte channel mapped at IO_BASE.
module mem_bus_responder #(
  parameter logic [15:0] IO_BASE        = 16'hBF00,
  parameter logic [15:0] NOP_WORD       = 16'h0800,
  parameter logic [3:0]  UART_INT_INDEX = 4'h3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mem_bus_responder_if.slave   cpu,
  output logic [15:0]          sram_addr_o,
  output logic [15:0]          sram_dq_out_o,
  output logic                 sram_dq_oe_o,
  input  logic [15:0]          sram_dq_in_i,
  output logic                 sram_ce_n_o,
  output logic                 sram_oe_n_o,
  output logic                 sram_we_n_o,
  input  logic                 uart_rx_valid_i,
  input  logic [7:0]           uart_rx_data_i,
  input  logic                 uart_tx_busy_i,
  output logic                 uart_tx_start_o,
  output logic [7:0]           uart_tx_data_o
);

  typedef enum logic {PH_I = 1'b0, PH_D = 1'b1} phase_e;

  function automatic logic is_io(input logic [15:0] addr);
    logic [15:0] off;
    off = addr - IO_BASE;
    return (off < 16'd4);
  endfunction

  phase_e      phase_q;
  logic        cpu_ce_q;
  logic [15:0] b_rdata_q;
  logic [15:0] a_rdata_q;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_full_q, rx_full_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        tx_drop_q, tx_drop_d;
  logic        int_en_q, int_en_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        hw_int_q;

  logic        a_io_s, b_io_s, rd_s, wr_s;
  logic [1:0]  a_off_s;
  logic [15:0] io_rdata_s, rd_data_s;
  logic        rx_drain_s, stat_rd_s, tx_wr_s, ie_wr_s;

  assign a_io_s     = is_io(cpu.a_addr);
  assign b_io_s     = is_io(cpu.b_addr);
  assign a_off_s    = cpu.a_addr[1:0] - IO_BASE[1:0];
  assign rd_s       = !rst_i && (phase_q == PH_D) && (cpu.a_ctrl == 2'b01);
  assign wr_s       = !rst_i && (phase_q == PH_D) && (cpu.a_ctrl == 2'b10);
  assign rx_drain_s = rd_s && a_io_s && (a_off_s == 2'd0);
  assign stat_rd_s  = rd_s && a_io_s && (a_off_s == 2'd1);
  assign tx_wr_s    = wr_s && a_io_s && (a_off_s == 2'd0);
  assign ie_wr_s    = wr_s && a_io_s && (a_off_s == 2'd2);

  // SRAM strobes follow the phase directly; reset forces every strobe inactive at once
  always_comb begin
    sram_addr_o   = cpu.b_addr;
    sram_dq_out_o = cpu.a_wdata;
    sram_dq_oe_o  = 1'b0;
    sram_ce_n_o   = 1'b1;
    sram_oe_n_o   = 1'b1;
    sram_we_n_o   = 1'b1;
    if (rst_i) begin
      sram_addr_o = cpu.b_addr;
    end else if (phase_q == PH_I) begin
      sram_ce_n_o = 1'b0;
      sram_oe_n_o = 1'b0;
    end else begin
      sram_addr_o = cpu.a_addr;
      if (rd_s && !a_io_s) begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
      end else if (wr_s && !a_io_s) begin
        sram_ce_n_o  = 1'b0;
        sram_we_n_o  = 1'b0;
        sram_dq_oe_o = 1'b1;
      end else begin
        sram_ce_n_o = 1'b1;
      end
    end
  end

  // IO register read mux
  always_comb begin
    case (a_off_s)
      2'd0:    io_rdata_s = {8'h00, rx_byte_q};
      2'd1:    io_rdata_s = {12'h000, tx_drop_q, rx_ovr_q, rx_full_q, !uart_tx_busy_i};
      2'd2:    io_rdata_s = {15'h0000, int_en_q};
      2'd3:    io_rdata_s = 16'h0000;
      default: io_rdata_s = 16'h0000;
    endcase
  end

  assign rd_data_s     = a_io_s ? io_rdata_s : sram_dq_in_i;
  assign cpu.a_rdata   = rd_s ? rd_data_s : a_rdata_q;
  assign cpu.b_rdata   = b_rdata_q;
  assign cpu.cpu_ce    = cpu_ce_q;
  assign cpu.hw_int_signal = hw_int_q;
  assign cpu.hw_int_index  = UART_INT_INDEX;
  assign uart_tx_start_o   = tx_start_q;
  assign uart_tx_data_o    = tx_data_q;

  // UART channel next state; a fresh rx byte outranks a same-cycle drain or status clear
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_full_d  = rx_full_q;
    rx_ovr_d   = rx_ovr_q;
    tx_drop_d  = tx_drop_q;
    int_en_d   = int_en_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (stat_rd_s) begin
      rx_ovr_d  = 1'b0;
      tx_drop_d = 1'b0;
    end else begin
      rx_ovr_d  = rx_ovr_q;
    end
    if (rx_drain_s) begin
      rx_full_d = 1'b0;
    end else begin
      rx_full_d = rx_full_q;
    end
    if (uart_rx_valid_i) begin
      rx_byte_d = uart_rx_data_i;
      rx_full_d = 1'b1;
      if (rx_full_q && !rx_drain_s) begin
        rx_ovr_d = 1'b1;
      end else begin
        rx_ovr_d = rx_ovr_d;
      end
    end else begin
      rx_byte_d = rx_byte_q;
    end
    if (tx_wr_s) begin
      if (!uart_tx_busy_i) begin
        tx_start_d = 1'b1;
        tx_data_d  = cpu.a_wdata[7:0];
      end else begin
        tx_drop_d = 1'b1;
      end
    end else begin
      tx_start_d = 1'b0;
    end
    if (ie_wr_s) begin
      int_en_d = cpu.a_wdata[0];
    end else begin
      int_en_d = int_en_q;
    end
  end

  // Phase FSM with registered CPU-side outputs and UART state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q    <= PH_I;
      cpu_ce_q   <= 1'b0;
      b_rdata_q  <= NOP_WORD;
      a_rdata_q  <= 16'h0000;
      rx_byte_q  <= 8'h00;
      rx_full_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_drop_q  <= 1'b0;
      int_en_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      hw_int_q   <= 1'b0;
    end else begin
      rx_byte_q  <= rx_byte_d;
      rx_full_q  <= rx_full_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_drop_q  <= tx_drop_d;
      int_en_q   <= int_en_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      hw_int_q   <= rx_full_d & int_en_d;
      case (phase_q)
        PH_I: begin
          phase_q   <= PH_D;
          cpu_ce_q  <= 1'b1;
          b_rdata_q <= b_io_s ? NOP_WORD : sram_dq_in_i;
        end
        PH_D: begin
          phase_q  <= PH_I;
          cpu_ce_q <= 1'b0;
          if (rd_s) begin
            a_rdata_q <= rd_data_s;
          end else begin
            a_rdata_q <= a_rdata_q;
          end
        end
        default: begin
          phase_q  <= PH_I;
          cpu_ce_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a behavioural async SRAM plus
// hand-computed expectations sampled 1 ns after each rising edge.
module tb_mem_bus_responder;
  logic        clk;
  logic        rst;
  logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic        rx_valid, tx_busy, tx_start;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] mem [0:65535];
  int          n_cmp;
  int          n_err;

  mem_bus_responder_if bus ();

  mem_bus_responder dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cpu             (bus.slave),
    .sram_addr_o     (sram_addr),
    .sram_dq_out_o   (sram_dq_out),
    .sram_dq_oe_o    (sram_dq_oe),
    .sram_dq_in_i    (sram_dq_in),
    .sram_ce_n_o     (sram_ce_n),
    .sram_oe_n_o     (sram_oe_n),
    .sram_we_n_o     (sram_we_n),
    .uart_rx_valid_i (rx_valid),
    .uart_rx_data_i  (rx_data),
    .uart_tx_busy_i  (tx_busy),
    .uart_tx_start_o (tx_start),
    .uart_tx_data_o  (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic [1:0] ctrl, input logic [15:0] addr, input logic [15:0] wdata);
    bus.a_ctrl  = ctrl;
    bus.a_addr  = addr;
    bus.a_wdata = wdata;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1234;
    mem[16'hFFFF] = 16'hF00D;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b1;
    bus.b_addr = 16'h0000;
    set_a(2'b00, 16'h0000, 16'h0000);

    step(); step();
    chk("rst_cpu_ce", {15'h0, bus.cpu_ce}, 16'h0000);
    chk("rst_we_n", {15'h0, sram_we_n}, 16'h0001);
    chk("rst_ce_n", {15'h0, sram_ce_n}, 16'h0001);
    chk("rst_dq_oe", {15'h0, sram_dq_oe}, 16'h0000);
    chk("rst_b_rdata", bus.b_rdata, 16'h0800);
    chk("rst_a_rdata", bus.a_rdata, 16'h0000);
    chk("rst_hw_int", {15'h0, bus.hw_int_signal}, 16'h0000);
    chk("rst_int_index", {12'h0, bus.hw_int_index}, 16'h0003);
    chk("rst_tx_start", {15'h0, tx_start}, 16'h0000);

    // idle phases: cpu_ce 0,1,0,1
    rst = 1'b0;
    #1;
    chk("idle0_ce", {15'h0, bus.cpu_ce}, 16'h0000);
    chk("idle0_sram_ce_n", {15'h0, sram_ce_n}, 16'h0000);
    step();
    chk("idle1_ce", {15'h0, bus.cpu_ce}, 16'h0001);
    chk("idle1_we_n", {15'h0, sram_we_n}, 16'h0001);
    chk("idle1_b_rdata", bus.b_rdata, 16'h1234);
    step();
    chk("idle2_ce", {15'h0, bus.cpu_ce}, 16'h0000);
    chk("idle2_b_rdata_hold", bus.b_rdata, 16'h1234);
    step();
    chk("idle3_ce", {15'h0, bus.cpu_ce}, 16'h0001);
    chk("idle3_we_n", {15'h0, sram_we_n}, 16'h0001);
    step();

    // SRAM write then read back
    set_a(2'b10, 16'h0100, 16'hBEEF);
    #1;
    chk("wr_phi_we_n", {15'h0, sram_we_n}, 16'h0001);
    step();
    chk("wr_phd_we_n", {15'h0, sram_we_n}, 16'h0000);
    chk("wr_phd_oe_n", {15'h0, sram_oe_n}, 16'h0001);
    chk("wr_phd_dq_oe", {15'h0, sram_dq_oe}, 16'h0001);
    chk("wr_phd_addr", sram_addr, 16'h0100);
    chk("wr_phd_dq_out", sram_dq_out, 16'hBEEF);
    step();
    set_a(2'b01, 16'h0100, 16'h0000);
    #1;
    chk("rd_phi_we_n", {15'h0, sram_we_n}, 16'h0001);
    chk("rd_phi_fetch", bus.b_rdata, 16'h1234);
    step();
    chk("rd_phd_a_rdata", bus.a_rdata, 16'hBEEF);
    step();
    chk("rd_phi_a_hold", bus.a_rdata, 16'hBEEF);
    chk("rd_fetch_unaffected", bus.b_rdata, 16'h1234);
    set_a(2'b00, 16'h0000, 16'h0000);
    step();
    chk("none_a_hold", bus.a_rdata, 16'hBEEF);
    chk("none_ce_n", {15'h0, sram_ce_n}, 16'h0001);
    step();

    // IO fetch with an IO data access; +3 reads zero
    bus.b_addr = 16'hBF00;
    set_a(2'b01, 16'hBF03, 16'h0000);
    #1;
    chk("iofetch_phi_ce_n", {15'h0, sram_ce_n}, 16'h0000);
    step();
    chk("iofetch_nop", bus.b_rdata, 16'h0800);
    chk("iofetch_phd_ce_n", {15'h0, sram_ce_n}, 16'h0001);
    chk("io3_rdata", bus.a_rdata, 16'h0000);
    step();
    bus.b_addr = 16'h0000;
    set_a(2'b01, 16'hFFFF, 16'h0000);
    step();
    chk("ffff_ce_n", {15'h0, sram_ce_n}, 16'h0000);
    chk("ffff_addr", sram_addr, 16'hFFFF);
    chk("ffff_rdata", bus.a_rdata, 16'hF00D);
    step();

    // interrupt enable, rx byte, status, drain
    set_a(2'b10, 16'hBF02, 16'h0001);
    step(); step();
    set_a(2'b01, 16'hBF02, 16'h0000);
    step();
    chk("int_en_rd", bus.a_rdata, 16'h0001);
    step();
    set_a(2'b00, 16'h0000, 16'h0000);
    rx_valid = 1'b1;
    rx_data = 8'h41;
    step();
    rx_valid = 1'b0;
    chk("rx_hw_int_set", {15'h0, bus.hw_int_signal}, 16'h0001);
    step();
    set_a(2'b01, 16'hBF01, 16'h0000);
    step();
    chk("stat_busy", bus.a_rdata, 16'h0002);
    step();
    set_a(2'b01, 16'hBF00, 16'h0000);
    step();
    chk("rx_read_41", bus.a_rdata, 16'h0041);
    chk("rx_int_during_read", {15'h0, bus.hw_int_signal}, 16'h0001);
    step();
    chk("rx_int_drop", {15'h0, bus.hw_int_signal}, 16'h0000);

    // rx overrun: two bytes without a read
    set_a(2'b00, 16'h0000, 16'h0000);
    rx_valid = 1'b1;
    rx_data = 8'h41;
    step();
    rx_data = 8'h42;
    step();
    rx_valid = 1'b0;
    set_a(2'b01, 16'hBF01, 16'h0000);
    step();
    chk("ovr_stat", bus.a_rdata, 16'h0006);
    step();
    set_a(2'b01, 16'hBF00, 16'h0000);
    step();
    chk("ovr_read_42", bus.a_rdata, 16'h0042);
    step();
    tx_busy = 1'b0;
    set_a(2'b01, 16'hBF01, 16'h0000);
    step();
    chk("ovr_cleared_idle", bus.a_rdata, 16'h0001);
    step();

    // rx arriving on the same cycle as the draining read
    rx_valid = 1'b1;
    rx_data = 8'h43;
    set_a(2'b01, 16'hBF00, 16'h0000);
    step();
    rx_data = 8'h44;
    chk("race_old_byte", bus.a_rdata, 16'h0043);
    step();
    rx_valid = 1'b0;
    chk("race_int_held", {15'h0, bus.hw_int_signal}, 16'h0001);
    set_a(2'b01, 16'hBF01, 16'h0000);
    step();
    chk("race_stat", bus.a_rdata, 16'h0003);
    step();
    set_a(2'b01, 16'hBF00, 16'h0000);
    step();
    chk("race_new_byte", bus.a_rdata, 16'h0044);
    step();
    chk("race_int_drop", {15'h0, bus.hw_int_signal}, 16'h0000);

    // transmit: idle then busy
    set_a(2'b10, 16'hBF00, 16'h0055);
    step();
    chk("tx_phd_no_pulse", {15'h0, tx_start}, 16'h0000);
    step();
    chk("tx_pulse", {15'h0, tx_start}, 16'h0001);
    chk("tx_data", {8'h00, tx_data}, 16'h0055);
    set_a(2'b00, 16'h0000, 16'h0000);
    step();
    chk("tx_pulse_end", {15'h0, tx_start}, 16'h0000);
    step();
    tx_busy = 1'b1;
    set_a(2'b10, 16'hBF00, 16'h0066);
    step(); step();
    chk("tx_busy_no_pulse", {15'h0, tx_start}, 16'h0000);
    set_a(2'b01, 16'hBF01, 16'h0000);
    step();
    chk("tx_drop_stat", bus.a_rdata, 16'h0008);
    chk("tx_data_kept", {8'h00, tx_data}, 16'h0055);
    step();

    // reset during a data-phase write
    set_a(2'b10, 16'h0200, 16'h1111);
    step();
    chk("rstwr_we_n_low", {15'h0, sram_we_n}, 16'h0000);
    rst = 1'b1;
    #1;
    chk("rstwr_we_n_same", {15'h0, sram_we_n}, 16'h0001);
    step();
    chk("rstwr_we_n_next", {15'h0, sram_we_n}, 16'h0001);
    chk("rstwr_cpu_ce", {15'h0, bus.cpu_ce}, 16'h0000);
    rst = 1'b0;
    set_a(2'b01, 16'h0200, 16'h0000);
    #1;
    chk("rstwr_phi_ce_n", {15'h0, sram_ce_n}, 16'h0000);
    step();
    chk("rstwr_phd_ce", {15'h0, bus.cpu_ce}, 16'h0001);
    chk("rstwr_not_written", bus.a_rdata, 16'h0000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the CPU memory interface: serves the instruction port (B) and data port (A) from one shared asynchronous 16-bit SRAM using a fixed two-phase schedule.
- Maps a UART byte channel and interrupt-enable register into the data space.
- Drives the CPU's hardware-interrupt request and a clock-enable (`cpu_ce`) that advances the CPU once per two `clk` cycles.
- Sits between the CPU top and the board SRAM/UART pins.

Parameters:
- `IO_BASE`, 16'hBF00, base of the 4-word IO window (`IO_BASE`..`IO_BASE`+3)
- `NOP_WORD`, 16'h0800, word returned for instruction fetches that hit the IO window
- `UART_INT_INDEX`, 4'h3, interrupt index reported for UART rx

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `cpu_ce`  out  1  CPU clock-enable; high exactly one cycle in two
- `b_addr`  in  16  instruction fetch address
- `b_rdata`  out  16  fetched instruction
- `a_addr`  in  16  data address
- `a_ctrl`  in  2  00 none, 01 read, 10 write, 11 treated as none
- `a_wdata`  in  16  store data
- `a_rdata`  out  16  load data
- `hw_int_signal`  out  1  interrupt request level
- `hw_int_index`  out  4  interrupt index
- `sram_addr`  out  16  SRAM address
- `sram_dq_out`  out  16  SRAM write data
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_out`
- `sram_dq_in`  in  16  SRAM read data
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low
- `uart_rx_valid`  in  1  one-cycle pulse, byte received
- `uart_rx_data`  in  8  received byte
- `uart_tx_busy`  in  1  transmitter busy
- `uart_tx_start`  out  1  one-cycle pulse, start transmit
- `uart_tx_data`  out  8  byte to transmit

Behaviour:
- **Phase FSM:** states `PH_I`, `PH_D`; `PH_I`→`PH_D`→`PH_I` unconditionally. `cpu_ce` = 1 only in `PH_D`.
- **Reset:**
  - FSM = `PH_I`.
  - `cpu_ce`, `sram_dq_oe`, `uart_tx_start`, `hw_int_signal` = 0.
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `b_rdata` = `NOP_WORD`; `a_rdata` = 0; `hw_int_index` = `UART_INT_INDEX`.
  - rx buffer empty; overrun = 0; `int_en` = 0.
  - Reset mid-write deasserts `sram_we_n` in the same cycle reset is sampled.
- **`PH_I`:**
  - `sram_addr` = `b_addr`; `ce_n`/`oe_n` = 0; `we_n` = 1.
  - At the end of the cycle, `b_rdata` registers `sram_dq_in`, or `NOP_WORD` if `b_addr` is in the IO window.
  - `b_rdata` then holds for two cycles.
- **`PH_D` SRAM read** (`a_ctrl`=01, non-IO address): `sram_addr` = `a_addr`; `oe_n` = 0. `a_rdata` = `sram_dq_in` combinationally during `PH_D`, registered at the end of `PH_D` and held through `PH_I`.
- **`PH_D` SRAM write** (`a_ctrl`=10, non-IO address): `sram_addr` = `a_addr`; `sram_dq_out` = `a_wdata`; `dq_oe` = 1; `oe_n` = 1; `we_n` = 0 for the whole `PH_D` cycle.
- **`PH_D` none:** all strobes inactive; `a_rdata` holds its previous value.
- **IO window:** accesses never touch SRAM (`ce_n` = 1 in `PH_D`).
  - +0 read: {8'h00, rx byte}; clears rx-full. Read while empty returns the last byte and has no side effect.
  - +0 write: if `!uart_tx_busy`, pulse `uart_tx_start` one cycle with `a_wdata[7:0]`; else drop the write and set overrun bit3.
  - +1 read: status {12'h0, tx_drop, overrun, rx_full, !uart_tx_busy}. Reading +1 clears both sticky bits.
  - +2: `int_en` = bit0 (read/write).
  - +3: reads 0; writes ignored.
- **Rx buffer:** 1 byte.
  - `uart_rx_valid` while full: overwrite the byte and set rx overrun (bit2).
  - `uart_rx_valid` in the same cycle as a +0 read: the read returns the old byte; the new byte is stored and rx-full stays 1.
- **Interrupt:** `hw_int_signal` = registered (`rx_full` & `int_en`), a level that drops the cycle after the draining read. `hw_int_index` is constant `UART_INT_INDEX`.
- **Address widths:** all 16-bit; no wrap logic. Address 16'hFFFF is a plain SRAM access.

Test Plan:
- Reset then 4 cycles with no access → `cpu_ce` toggles 0,1,0,1; `sram_we_n` = 1 throughout; `b_rdata` tracks SRAM at `b_addr`=0.
- Write `a_addr`=16'h0100, `a_wdata`=16'hBEEF, then read 16'h0100 → `we_n` low only in `PH_D`; `a_rdata`=16'hBEEF in next `PH_D` and held through `PH_I`; an interleaved fetch at 16'h0000 is unaffected.
- Fetch `b_addr`=16'hBF00 → `b_rdata`=16'h0800; SRAM `ce_n` high only if `PH_D` is also IO.
- `uart_rx_valid` with 8'h41, `int_en`=1 → `hw_int_signal`=1; read 16'hBF01 = 16'h0002 (tx busy) or 16'h0003 (tx idle); read 16'hBF00 = 16'h0041; `hw_int_signal`=0 one cycle later.
- Two rx pulses (8'h41, 8'h42) with no read → read 16'hBF01 bit2=1, read 16'hBF00 = 16'h0042; a second 16'hBF01 read shows bit2=0.
- Write 16'hBF00 = 16'h0055 with `uart_tx_busy`=0 → one-cycle `uart_tx_start`, `uart_tx_data`=8'h55. Same write with busy=1 → no pulse; status bit3=1. Assert `rst` during a `PH_D` write → `we_n`=1 the next cycle; FSM in `PH_I`.
